// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared widths, state encoding and port indices for the memory arbiter
package mem_if_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 256;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin pick with a last-grant register
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic       gnt_o,
    output logic       last_grant_o
);
    import mem_if_pkg::*;

    logic last_grant_d, last_grant_q;

    // On a tie the port that did not win last time goes next; with no request gnt_o is don't-care.
    always_comb begin
        gnt_o = (req_i == 2'b11) ? ~last_grant_q : req_i[1];
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (advance_i) begin
            last_grant_d = gnt_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_grant_q <= PORT_D;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign last_grant_o = last_grant_q;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin sharing of one cache-line memory port between I-cache and D-cache
module mem_arbiter
    import mem_if_pkg::*;
#(
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int DATA_W      = MEM_DATA_W,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p0_enable_i,
    input  logic              p0_write_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_data_i,
    output logic              p0_ack_o,
    output logic [DATA_W-1:0] p0_data_o,
    input  logic              p1_enable_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_data_i,
    output logic              p1_ack_o,
    output logic [DATA_W-1:0] p1_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic              busy_o,
    output logic              grant_o,
    output logic              timeout_o
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYC);

    state_e            state_d, state_q;
    logic              wr_d, wr_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [DATA_W-1:0] data_d, data_q;
    logic [CW-1:0]     wdog_d, wdog_q;
    logic              timeout_d, timeout_q;

    logic [1:0] req;
    logic       gnt;
    logic       last_grant;
    logic       advance;
    logic       busy;

    assign req     = {p1_enable_i, p0_enable_i};
    assign busy    = (state_q == ST_BUSY);
    assign advance = !busy && (req != 2'b00);

    rr_arb2 u_rr_arb2 (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req),
        .advance_i    (advance),
        .gnt_o        (gnt),
        .last_grant_o (last_grant)
    );

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wdog_d    = wdog_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (advance) begin
                    state_d = ST_BUSY;
                    wr_d    = (gnt == PORT_D) ? p1_write_i : p0_write_i;
                    addr_d  = (gnt == PORT_D) ? p1_addr_i  : p0_addr_i;
                    data_d  = (gnt == PORT_D) ? p1_data_i  : p0_data_i;
                    wdog_d  = '0;
                end
            end
            ST_BUSY: begin
                // Saturating count; the flag is sticky and the FSM keeps waiting for the ack.
                if (wdog_q != TO_MAX) begin
                    wdog_d = wdog_q + CW'(1);
                end
                if ((TIMEOUT_CYC != 0) && (wdog_d == TO_MAX)) begin
                    timeout_d = 1'b1;
                end
                if (mem_ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign mem_enable_o = busy;
    assign mem_write_o  = wr_q;
    assign mem_addr_o   = addr_q;
    assign mem_data_o   = data_q;
    assign busy_o       = busy;
    assign grant_o      = last_grant;
    assign timeout_o    = timeout_q;

    // Acks outside BUSY are dropped, so stray or post-reset acks never reach a cache.
    assign p0_ack_o  = busy && mem_ack_i && (last_grant == PORT_I);
    assign p1_ack_o  = busy && mem_ack_i && (last_grant == PORT_D);
    assign p0_data_o = mem_data_i;
    assign p1_data_o = mem_data_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         p0_enable_i, p0_write_i, p1_enable_i, p1_write_i;
    logic [31:0]  p0_addr_i, p1_addr_i;
    logic [255:0] p0_data_i, p1_data_i;
    logic         p0_ack_o, p1_ack_o;
    logic [255:0] p0_data_o, p1_data_o;
    logic         mem_enable_o, mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o, mem_data_i;
    logic         mem_ack_i;
    logic         busy_o, grant_o, timeout_o;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(256), .TIMEOUT_CYC(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .p0_enable_i  (p0_enable_i),
        .p0_write_i   (p0_write_i),
        .p0_addr_i    (p0_addr_i),
        .p0_data_i    (p0_data_i),
        .p0_ack_o     (p0_ack_o),
        .p0_data_o    (p0_data_o),
        .p1_enable_i  (p1_enable_i),
        .p1_write_i   (p1_write_i),
        .p1_addr_i    (p1_addr_i),
        .p1_data_i    (p1_data_i),
        .p1_ack_o     (p1_ack_o),
        .p1_data_o    (p1_data_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i),
        .busy_o       (busy_o),
        .grant_o      (grant_o),
        .timeout_o    (timeout_o)
    );

    typedef struct {
        logic         p0_en;
        logic         p1_en;
        logic         wr;
        logic [31:0]  a0;
        logic [31:0]  a1;
        logic [255:0] rd;
        logic         en_exp;
        logic         g_exp;
        logic [31:0]  addr_exp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_enable_i = 0; p1_enable_i = 0; p0_write_i = 0; p1_write_i = 0;
        p0_addr_i = '0; p1_addr_i = '0; p0_data_i = '0; p1_data_i = '0;
        mem_data_i = '0; mem_ack_i = 0;
    endtask

    task automatic do_reset();
        rst_i = 0;
        tick();
        tick();
        rst_i = 1;
        tick();
    endtask

    initial begin
        idle_inputs();
        rst_i = 0;

        // Reset with both ports requesting: outputs stay quiet, port 0 wins first.
        p0_enable_i = 1; p1_enable_i = 1;
        p0_addr_i = 32'h0000_1000; p1_addr_i = 32'h0000_2000;
        p0_data_i = {8{32'h1111_1111}}; p1_data_i = {8{32'h2222_2222}};
        tick(); tick();
        chk("rst_mem_enable", 256'(mem_enable_o), 256'(0));
        chk("rst_mem_write", 256'(mem_write_o), 256'(0));
        chk("rst_mem_addr", 256'(mem_addr_o), 256'(0));
        chk("rst_mem_data", mem_data_o, 256'(0));
        chk("rst_busy", 256'(busy_o), 256'(0));
        chk("rst_timeout", 256'(timeout_o), 256'(0));
        chk("rst_grant", 256'(grant_o), 256'(1));
        rst_i = 1;
        tick();
        chk("first_grant", 256'(grant_o), 256'(0));
        chk("first_addr", 256'(mem_addr_o), 256'(32'h0000_1000));
        chk("first_enable", 256'(mem_enable_o), 256'(1));
        mem_ack_i = 1; #1;
        tick();
        idle_inputs();

        // Table: arbitration sequence from reset (last_grant=1).
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h200, {8{32'hC0DE_0001}}, 1'b1, 1'b0, 32'h100};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h110, 32'h210, {8{32'hC0DE_0002}}, 1'b1, 1'b1, 32'h210};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h120, 32'h220, {8{32'hC0DE_0003}}, 1'b1, 1'b0, 32'h120};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h130, 32'h230, {8{32'hC0DE_0004}}, 1'b1, 1'b1, 32'h230};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h140, 32'h240, {8{32'hC0DE_0005}}, 1'b1, 1'b0, 32'h140};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h150, 32'h250, {8{32'hC0DE_0006}}, 1'b1, 1'b0, 32'h150};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h160, 32'h260, {8{32'hC0DE_0007}}, 1'b1, 1'b1, 32'h260};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 32'h170, 32'h270, {8{32'hC0DE_0008}}, 1'b0, 1'b1, 32'h0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            p0_enable_i = vecs[i].p0_en; p1_enable_i = vecs[i].p1_en;
            p0_write_i = vecs[i].wr; p1_write_i = vecs[i].wr;
            p0_addr_i = vecs[i].a0; p1_addr_i = vecs[i].a1;
            p0_data_i = {8{vecs[i].a0}}; p1_data_i = {8{vecs[i].a1}};
            tick();
            chk($sformatf("v%0d_enable", i), 256'(mem_enable_o), 256'(vecs[i].en_exp));
            chk($sformatf("v%0d_grant", i), 256'(grant_o), 256'(vecs[i].g_exp));
            if (vecs[i].en_exp) begin
                chk($sformatf("v%0d_addr", i), 256'(mem_addr_o), 256'(vecs[i].addr_exp));
                chk($sformatf("v%0d_wdata", i), mem_data_o, {8{vecs[i].addr_exp}});
                chk($sformatf("v%0d_write", i), 256'(mem_write_o), 256'(vecs[i].wr));
                mem_data_i = vecs[i].rd; mem_ack_i = 1; #1;
                chk($sformatf("v%0d_p0_ack", i), 256'(p0_ack_o), 256'(!vecs[i].g_exp));
                chk($sformatf("v%0d_p1_ack", i), 256'(p1_ack_o), 256'(vecs[i].g_exp));
                chk($sformatf("v%0d_rdata", i), vecs[i].g_exp ? p1_data_o : p0_data_o, vecs[i].rd);
                tick();
                idle_inputs();
                chk($sformatf("v%0d_drop", i), 256'(mem_enable_o), 256'(0));
            end
            idle_inputs();
            tick();
        end

        // p1 read with a slow memory: exactly one ack pulse.
        do_reset();
        begin
            int p0_cnt = 0, p1_cnt = 0;
            logic [255:0] got = '0;
            p1_enable_i = 1; p1_addr_i = 32'h0000_0400;
            for (int c = 1; c <= 16; c++) begin
                tick();
                if (c == 11) begin
                    p1_enable_i = 0;
                end
                mem_ack_i = (c == 10);
                mem_data_i = (c == 10) ? {32{8'hA5}} : '0;
                #1;
                if (p1_ack_o) begin p1_cnt++; got = p1_data_o; end
                if (p0_ack_o) p0_cnt++;
            end
            chk("slow_p1_pulses", 256'(p1_cnt), 256'(1));
            chk("slow_p0_pulses", 256'(p0_cnt), 256'(0));
            chk("slow_p1_data", got, {32{8'hA5}});
            idle_inputs();
        end

        // Both ports always requesting: strict alternation with one bubble.
        do_reset();
        p0_enable_i = 1; p1_enable_i = 1;
        p0_addr_i = 32'hA0; p1_addr_i = 32'hB0;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk($sformatf("fair%0d_enable", t), 256'(mem_enable_o), 256'(1));
            chk($sformatf("fair%0d_grant", t), 256'(grant_o), 256'(t % 2));
            tick();
            mem_ack_i = 1; #1;
            chk($sformatf("fair%0d_ack", t), 256'({p1_ack_o, p0_ack_o}), (t % 2) ? 256'(2) : 256'(1));
            tick();
            mem_ack_i = 0;
            chk($sformatf("fair%0d_bubble", t), 256'(mem_enable_o), 256'(0));
        end
        idle_inputs();
        tick();

        // Latched write request ignores later input changes.
        do_reset();
        p0_enable_i = 1; p0_write_i = 1; p0_addr_i = 32'h20; p0_data_i = {4{64'hDEAD_BEEF_0123_4567}};
        tick();
        p0_addr_i = 32'h999; p0_data_i = '1; p0_write_i = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("hold%0d_addr", c), 256'(mem_addr_o), 256'(32'h20));
            chk($sformatf("hold%0d_data", c), mem_data_o, {4{64'hDEAD_BEEF_0123_4567}});
            chk($sformatf("hold%0d_write", c), 256'(mem_write_o), 256'(1));
        end
        mem_ack_i = 1; #1;
        chk("hold_ack", 256'(p0_ack_o), 256'(1));
        tick();
        idle_inputs();
        tick();

        // Watchdog: sets after 8 BUSY cycles, stays set through a late ack.
        do_reset();
        p0_enable_i = 1; p0_addr_i = 32'h44;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("wd_pre%0d", k), 256'(timeout_o), 256'(0));
        end
        tick();
        chk("wd_set", 256'(timeout_o), 256'(1));
        for (int k = 0; k < 5; k++) tick();
        chk("wd_sticky", 256'(timeout_o), 256'(1));
        chk("wd_still_busy", 256'(busy_o), 256'(1));
        mem_ack_i = 1; #1;
        chk("wd_late_ack", 256'(p0_ack_o), 256'(1));
        tick();
        idle_inputs();
        chk("wd_after_ack_timeout", 256'(timeout_o), 256'(1));
        chk("wd_after_ack_busy", 256'(busy_o), 256'(0));

        // Reset mid-BUSY followed by a stray ack.
        do_reset();
        p1_enable_i = 1; p1_addr_i = 32'h88;
        tick();
        chk("mid_busy", 256'(busy_o), 256'(1));
        rst_i = 0; #1;
        chk("mid_rst_enable", 256'(mem_enable_o), 256'(0));
        chk("mid_rst_grant", 256'(grant_o), 256'(1));
        tick();
        rst_i = 1; p1_enable_i = 0;
        tick(); tick();
        mem_ack_i = 1; mem_data_i = {8{32'hBAD0_BAD0}}; #1;
        chk("stray_acks", 256'({p1_ack_o, p0_ack_o}), 256'(0));
        tick();
        mem_ack_i = 0;
        chk("stray_idle", 256'(busy_o), 256'(0));
        chk("stray_enable", 256'(mem_enable_o), 256'(0));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port round-robin arbiter that shares the single 256-bit data-memory interface between the instruction cache (port 0) and the data cache (port 1).
- Sits between the CPU's two cache controllers and the off-chip Data_Memory model.
- Latches the winning request, holds it stable toward memory until mem_ack_i, then routes the ack and read data back to the winner.
- Includes a per-transaction watchdog that flags a memory that never acknowledges.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 256, cache-line width.
- TIMEOUT_CYC, 1023, cycles a transaction may stay outstanding before timeout_o is set; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-low
- p0_enable_i  in  1  port-0 request; held until p0_ack_o
- p0_write_i  in  1  port-0 write (1) / read (0)
- p0_addr_i  in  ADDR_W  port-0 line address
- p0_data_i  in  DATA_W  port-0 write data
- p0_ack_o  out  1  port-0 completion pulse
- p0_data_o  out  DATA_W  port-0 read data, valid when p0_ack_o=1
- p1_enable_i / p1_write_i / p1_addr_i / p1_data_i / p1_ack_o / p1_data_o: same as port 0, for port 1
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  memory write
- mem_addr_o  out  ADDR_W  memory address
- mem_data_o  out  DATA_W  memory write data
- mem_data_i  in  DATA_W  memory read data
- mem_ack_i  in  1  memory completion pulse (one cycle)
- busy_o  out  1  transaction outstanding
- grant_o  out  1  owner of the current or last transaction (0/1)
- timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State goes to IDLE.
  - mem_enable_o, mem_write_o, busy_o, timeout_o = 0; mem_addr_o, mem_data_o = 0.
  - last_grant = 1, so port 0 wins the first tie; grant_o = 1.
  - Watchdog counter = 0.
- States: IDLE, BUSY.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant !last_grant.
  - On grant, register write/addr/data from the winner, set last_grant = winner, go to BUSY.
  - mem_enable_o rises on the cycle after the request is first seen. Arbitration latency is 1 cycle.
- BUSY:
  - mem_enable_o = 1; mem_write_o/addr/data come from the latched copy and ignore later input changes.
  - busy_o = 1; grant_o = winner.
- mem_ack_i=1 in BUSY:
  - Winner's pN_ack_o = 1 combinationally in the same cycle; the loser's ack stays 0.
  - Next state is IDLE; mem_enable_o drops on the next edge.
  - Minimum one IDLE cycle between transactions, so back-to-back requests cost 1 bubble.
- p0_data_o and p1_data_o = mem_data_i (broadcast); only meaningful alongside the matching ack.
- mem_ack_i outside BUSY: ignored. Covers stray acks and acks arriving after a mid-transaction reset.
- Requester drops enable before its ack: the transaction still completes to memory; the ack is still pulsed and may be ignored by the requester.
- Fairness: with both ports continuously requesting, grants strictly alternate 0,1,0,1.
- Watchdog:
  - Counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYC (TIMEOUT_CYC != 0), timeout_o sets and stays set until reset. The FSM keeps waiting.
  - The counter saturates at TIMEOUT_CYC.
- Write/read mix: no special casing; write data is driven the whole time in BUSY.

Decomposition:
- Shared package mem_if_pkg:
  - ADDR_W and DATA_W defaults.
  - State encoding constants ST_IDLE=1'b0, ST_BUSY=1'b1.
  - Port index constants PORT_I=0, PORT_D=1.
- One natural sub-module, rr_arb2: a 2-input round-robin pick with a last_grant register and an advance enable.
- Request latch, watchdog and ack routing stay in mem_arbiter.

Test Plan:
- Reset with p0 and p1 both requesting and rst_i low, then release -> first grant_o=0 and mem_addr_o=p0_addr_i one cycle later; all outputs 0 during reset.
- p1 only, read 0x0000_0400, memory acks after 10 cycles with 256'hA5..A5 -> p1_ack_o pulses exactly once with p1_data_o=A5..A5; p0_ack_o stays 0.
- Both ports hold requests for 4 transactions -> grant sequence 0,1,0,1; one IDLE cycle between each mem_ack_i and the next mem_enable_o.
- p0 write to 0x20 with data D, then p0_addr_i/p0_data_i changed during BUSY -> mem_addr_o=0x20 and mem_data_o=D until ack.
- TIMEOUT_CYC=8, memory never acks -> timeout_o rises at BUSY cycle 8 and stays set; a later ack still completes the transaction with timeout_o still 1.
- rst_i asserted mid-BUSY, stray mem_ack_i two cycles after release with no requests -> no pN_ack_o pulse; state stays IDLE.
